// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer: iterative shift-add multiply and restoring divide into HI/LO.
// Optional MULDIV_SIGNED_EN build macro switches to two's-complement operands via magnitude/sign fix-up.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] ALU_MULT = 3'b101;
  localparam logic [2:0] ALU_DIV  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               dbz_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               legal_op;
  logic               accept;
  logic               dbz_accept;

  // Handshake: start is a request taken only in IDLE with a legal alu_ctrl (no queueing);
  // done is a one-cycle valid for hi/lo and has no backpressure.
  assign legal_op   = (alu_ctrl == ALU_MULT) || (alu_ctrl == ALU_DIV);
  assign accept     = (state == S_IDLE) && start && legal_op;
  assign dbz_accept = accept && (alu_ctrl == ALU_DIV) && (op_b == '0);

`ifdef MULDIV_SIGNED_EN
  logic               a_neg_q;
  logic               b_neg_q;
  logic [2*WIDTH-1:0] prod;

  assign mag_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign mag_b = op_b[WIDTH-1] ? -op_b : op_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
    end else if (accept) begin
      a_neg_q <= op_a[WIDTH-1];
      b_neg_q <= op_b[WIDTH-1];
    end
  end

  // Quotient negates on differing signs; remainder follows the dividend's sign.
  always_comb begin
    prod   = acc;
    res_hi = acc[2*WIDTH-1:WIDTH];
    res_lo = acc[WIDTH-1:0];
    if (is_div) begin
      if (a_neg_q ^ b_neg_q) res_lo = -acc[WIDTH-1:0];
      if (a_neg_q)           res_hi = -acc[2*WIDTH-1:WIDTH];
    end else if (a_neg_q ^ b_neg_q) begin
      prod   = -acc;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end
`else
  assign mag_a  = op_a;
  assign mag_b  = op_b;
  assign res_hi = acc[2*WIDTH-1:WIDTH];
  assign res_lo = acc[WIDTH-1:0];
`endif

  // One iteration of either algorithm; acc holds {upper, lower} or {rem, quot}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    acc_step  = acc;
    if (is_div) begin
      if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_step = {mul_sum, acc[WIDTH-1:1]};
      else        acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = dbz_accept ? S_FINISH : S_CALC;
      end
      S_CALC: begin
        if (cnt == CW'(1)) state_nxt = S_FINISH;
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_CALC) || (state == S_FINISH);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      dbz_q       <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            is_div      <= (alu_ctrl == ALU_DIV);
            dbz_q       <= dbz_accept;
            div_by_zero <= 1'b0;
            cnt         <= CW'(WIDTH);
            if (dbz_accept) begin
              // Divide-by-zero result is staged directly, bypassing the core.
              acc  <= {op_a, {WIDTH{1'b1}}};
              opnd <= '0;
            end else if (alu_ctrl == ALU_DIV) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt - CW'(1);
          acc <= acc_step;
        end
        S_FINISH: begin
          done <= 1'b1;
          if (dbz_q) begin
            hi          <= acc[2*WIDTH-1:WIDTH];
            lo          <= acc[WIDTH-1:0];
            div_by_zero <= 1'b1;
          end else begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic reference model compared every cycle,
// plus literal HI/LO/latency expectations per operation.
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;
  localparam logic [2:0] OP_MULT = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  alu_ctrl = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: cycles left until done, pending result, visible registers.
  int          m_rem = 0;
  logic        m_done = 1'b0;
  logic        m_dbz = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  logic        m_pend_dbz = 1'b0;

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alu_ctrl   (alu_ctrl),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // {hi, lo} straight from arithmetic on the operands.
  function automatic logic [63:0] model_result(input logic [2:0] ctrl, input logic [31:0] a,
                                               input logic [31:0] b);
`ifdef MULDIV_SIGNED_EN
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (ctrl == OP_DIV && b == 0) return {a, 32'hFFFF_FFFF};
    if (ctrl == OP_MULT) return 64'(sa * sb);
    q = sa / sb;
    r = sa % sb;
    return {32'(r), 32'(q)};
`else
    logic [63:0] ua, ub;
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (ctrl == OP_DIV && b == 0) return {a, 32'hFFFF_FFFF};
    if (ctrl == OP_MULT) return ua * ub;
    return {a % b, a / b};
`endif
  endfunction

  always begin
    @(posedge clk);
    if (reset) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1;
          m_hi   = m_pend[63:32];
          m_lo   = m_pend[31:0];
          m_dbz  = m_pend_dbz;
        end
      end else if (start && (alu_ctrl == OP_MULT || alu_ctrl == OP_DIV)) begin
        m_pend     = model_result(alu_ctrl, op_a, op_b);
        m_pend_dbz = (alu_ctrl == OP_DIV) && (op_b == 0);
        m_dbz      = 1'b0;
        m_rem      = m_pend_dbz ? 1 : WIDTH + 1;
      end
    end
    @(negedge clk);
    check("cyc busy", busy, m_rem > 0);
    check("cyc done", done, m_done);
    check("cyc div_by_zero", div_by_zero, m_dbz);
    check("cyc hi", hi, m_hi);
    check("cyc lo", lo, m_lo);
  end

  // Issue one op, optionally poke a second start mid-run, then wait (bounded) for done.
  task automatic run_op(input string name, input logic [2:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dbz, input int exp_done_cyc, input int poke_at);
    int   cyc;
    int   busy_cnt;
    logic seen;
    @(posedge clk); #1;
    start = 1'b1; alu_ctrl = ctrl; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; alu_ctrl = 3'b000;
    cyc = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else if (cyc == poke_at) begin
        start = 1'b1; alu_ctrl = OP_MULT; op_a = 32'd9; op_b = 32'd9;
      end else if (cyc == poke_at + 1) begin
        start = 1'b0; alu_ctrl = 3'b000;
      end
    end
    start = 1'b0;
    check({name, " done_seen"}, seen, 1'b1);
    check({name, " done_cycle"}, cyc, exp_done_cyc);
    check({name, " busy_cycles"}, busy_cnt, exp_done_cyc - 1);
    check({name, " hi"}, hi, exp_hi);
    check({name, " lo"}, lo, exp_lo);
    check({name, " div_by_zero"}, div_by_zero, exp_dbz);
  endtask

  task automatic count_quiet(input string name, input int cycles);
    int n_busy;
    int n_done;
    n_busy = 0; n_done = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (done) n_done++;
    end
    check({name, " busy_count"}, n_busy, 0);
    check({name, " done_count"}, n_done, 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset div_by_zero", div_by_zero, 1'b0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);

`ifndef MULDIV_SIGNED_EN
    run_op("mul7x6", OP_MULT, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0, 34, 0);
    run_op("mulmax", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 34, 0);
    run_op("div100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 10);
    run_op("div5_0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2, 0);
    run_op("mul3x4", OP_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 34, 0);
    run_op("div3_10", OP_DIV, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 34, 0);
    run_op("divmax_1", OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0, 34, 0);
    run_op("mulmsb", OP_MULT, 32'h8000_0000, 32'd2, 32'h1, 32'h0, 1'b0, 34, 0);
`else
    run_op("smul", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, 0);
    run_op("sdiv", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 10);
    run_op("sdiv_mn", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, 0);
    run_op("div5_0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2, 0);
    run_op("mul3x4", OP_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 34, 0);
`endif

    // Reset lands on the tenth iteration of a multiply.
    @(posedge clk); #1;
    start = 1'b1; alu_ctrl = OP_MULT; op_a = 32'd123; op_b = 32'd456;
    @(posedge clk); #1;
    start = 1'b0; alu_ctrl = 3'b000;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset busy", busy, 1'b0);
    check("midreset done", done, 1'b0);
    check("midreset hi", hi, 32'h0);
    check("midreset lo", lo, 32'h0);
    count_quiet("midreset", 40);

    @(posedge clk); #1;
    start = 1'b1; alu_ctrl = 3'b000; op_a = 32'd1; op_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    count_quiet("illegal000", 40);

    @(posedge clk); #1;
    start = 1'b1; alu_ctrl = 3'b111; op_a = 32'd8; op_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; alu_ctrl = 3'b000;
    count_quiet("illegal111", 40);

    run_op("after_reset", OP_MULT, 32'd11, 32'd13, 32'h0, 32'd143, 1'b0, 34, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the MULT (ALUControl 3'b101) and DIV (ALUControl 3'b110) operations.
- Runs an iterative shift-add multiply or restoring divide over WIDTH cycles and holds the result in HI/LO registers.
- Raises busy so the pipeline stalls while it is working.
- Sits beside the main ALU in the execute stage. The single-cycle ALU keeps all other opcodes.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- alu_ctrl  input  3  ALU control code: 3'b101 = MULT, 3'b110 = DIV; any other code is ignored.
- op_a  input  WIDTH  multiplicand or dividend; captured when start is accepted.
- op_b  input  WIDTH  multiplier or divisor; captured when start is accepted.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse when HI/LO update.
- div_by_zero  output  1  sticky flag; set by DIV with op_b == 0; cleared by the next accepted start.
- hi  output  WIDTH  MULT: upper product half. DIV: remainder.
- lo  output  WIDTH  MULT: lower product half. DIV: quotient.

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-operation):
  - state = IDLE, counter = 0.
  - busy = 0, done = 0, div_by_zero = 0, hi = 0, lo = 0.
  - Any in-flight operation is discarded.
- States: IDLE, CALC, FINISH.
- IDLE:
  - If start = 1 and alu_ctrl is 101 or 110: capture op_a, op_b and the op; clear div_by_zero; go to CALC; set counter = WIDTH.
  - If start = 1 with any other alu_ctrl: no action, stay in IDLE.
  - Otherwise stay in IDLE.
- Divide by zero: on acceptance, DIV with op_b == 0 goes directly to FINISH.
  - Result: hi = op_a, lo = all ones, div_by_zero = 1.
- CALC: one iteration per cycle; counter decrements; on the iteration where counter == 1, go to FINISH.
  - MULT: internal 2*WIDTH accumulator. If the multiplier LSB = 1, add the multiplicand to the upper half. Then shift the accumulator right by 1 including the carry-out. Exact unsigned product, no overflow.
  - DIV: restoring division. Shift {rem, quot} left by 1. Trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quotient LSB; else restore.
- FINISH (exactly one cycle): load hi/lo from the internal result; done = 1; go to IDLE.
- busy:
  - 1 while state is CALC or FINISH.
  - 0 in IDLE, including the cycle in which start is accepted.
  - The stall logic ORs start-acceptance with busy.
- Latency: start accepted at edge N.
  - busy = 1 after edges N through N+WIDTH.
  - done = 1 and hi/lo valid after edge N+WIDTH+1.
  - Divide-by-zero: done after edge N+1.
- start while busy: ignored, not queued.
- hi/lo: change only on the done cycle or reset; otherwise hold their values for MFHI/MFLO reads.
- done and busy never pulse without an accepted start.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken on acceptance and the unsigned core runs on them.
  - Product sign = sign(a) XOR sign(b), applied in FINISH by negating {hi, lo}.
  - Quotient is negated if signs differ. Remainder takes the sign of the dividend.
  - Most-negative / -1: lo = most-negative value, hi = 0, no flag.
  - Divide by zero: same as unsigned.
- Undefined: fully unsigned; no sign logic is instantiated.

Test Plan:
- MULT 7 x 6 (WIDTH = 32) → busy high for 33 cycles; done on cycle 34; hi = 0, lo = 42.
- MULT 32'hFFFFFFFF x 32'hFFFFFFFF, unsigned → hi = 32'hFFFFFFFE, lo = 32'h00000001.
- DIV 100 / 7 → lo = 14, hi = 2, div_by_zero = 0; start pulsed again mid-CALC is ignored and latency is unchanged.
- DIV 5 / 0 → done after 1 cycle, hi = 5, lo = 32'hFFFFFFFF, div_by_zero = 1; next accepted MULT clears the flag.
- reset asserted at iteration 10 of a MULT → next cycle busy = 0, hi = lo = 0, no done pulse; start with alu_ctrl = 3'b000 → no busy, no done.
- With MULDIV_SIGNED_EN: MULT -3 x 5 → {hi, lo} = -15 (hi = 32'hFFFFFFFF, lo = 32'hFFFFFFF1); DIV -7 / 2 → lo = -3, hi = -1.
